// File: rtl/set_assoc_cache_pkg.sv
// Shared configuration for the set-associative cache: default geometry,
// the reference line layout and the controller state encoding.
package cache_config;

    localparam int CACHE_WAYS       = 4;
    localparam int CACHE_SETS       = 32;
    localparam int CACHE_BLOCK_SIZE = 16;
    localparam int CACHE_ADDR_SIZE  = 32;

    localparam int CACHE_TAG_W  = CACHE_ADDR_SIZE - $clog2(CACHE_BLOCK_SIZE) - $clog2(CACHE_SETS);
    localparam int CACHE_AGE_W  = $clog2(CACHE_WAYS);
    localparam int CACHE_LINE_W = CACHE_BLOCK_SIZE * 8;

    // Line layout at the default geometry; the cache body declares the same
    // field order sized from its own parameters.
    typedef struct packed {
        logic                    valid;
        logic                    dirty;
        logic [CACHE_TAG_W-1:0]  tag;
        logic [CACHE_AGE_W-1:0]  age;
        logic [CACHE_LINE_W-1:0] data;
    } cache_line_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_REFILL,
        ST_RESPOND
    } cache_state_t;

    // Saturating 32-bit increment used by the optional statistics counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (&value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/set_assoc_cache_lru.sv
// Age-based LRU helper: picks a victim way for a set and computes the
// updated age vector when one way is accessed.
module cache_lru #(
    parameter  int WAYS  = 4,
    localparam int AGE_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]       valid,
    input  logic [WAYS*AGE_W-1:0] ages,
    input  logic [AGE_W-1:0]      access_way,
    output logic [AGE_W-1:0]      victim_way,
    output logic [WAYS*AGE_W-1:0] new_ages
);

    logic             any_invalid;
    logic [AGE_W-1:0] access_age;

    // Lowest-index invalid way wins; otherwise the oldest (age WAYS-1) way.
    always_comb begin
        victim_way  = '0;
        any_invalid = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim_way  = AGE_W'(w);
                any_invalid = 1'b1;
            end
        end
        if (!any_invalid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (ages[w*AGE_W +: AGE_W] == AGE_W'(WAYS - 1)) begin
                    victim_way = AGE_W'(w);
                end
            end
        end
    end

    assign access_age = ages[access_way*AGE_W +: AGE_W];

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_age
            logic [AGE_W-1:0] age_gi;
            assign age_gi = ages[gi*AGE_W +: AGE_W];
            assign new_ages[gi*AGE_W +: AGE_W] =
                (AGE_W'(gi) == access_way) ? '0 :
                (age_gi < access_age)      ? age_gi + AGE_W'(1) : age_gi;
        end
    endgenerate

endmodule

// File: rtl/set_assoc_cache.sv
// Write-back, write-allocate set-associative cache with LRU replacement.
// Define CACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module set_assoc_cache
    import cache_config::*;
#(
    parameter int WAYS       = CACHE_WAYS,
    parameter int SETS       = CACHE_SETS,
    parameter int BLOCK_SIZE = CACHE_BLOCK_SIZE,
    parameter int ADDR_SIZE  = CACHE_ADDR_SIZE,
    parameter int DATA_SIZE  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_SIZE-1:0]    req_addr,
    input  logic [DATA_SIZE-1:0]    req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_SIZE-1:0]    rsp_rdata,
    output logic                    rsp_hit,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_we,
    output logic [ADDR_SIZE-1:0]    mem_req_addr,
    output logic [BLOCK_SIZE*8-1:0] mem_req_wline,
    input  logic                    mem_rsp_valid,
    input  logic [BLOCK_SIZE*8-1:0] mem_rsp_rline
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
`endif
);

    localparam int OFF_W  = $clog2(BLOCK_SIZE);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_SIZE - OFF_W - IDX_W;
    localparam int AGE_W  = $clog2(WAYS);
    localparam int LINE_W = BLOCK_SIZE * 8;
    localparam int WB     = $clog2(DATA_SIZE / 8);

    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [TAG_W-1:0]  tag;
        logic [AGE_W-1:0]  age;
        logic [LINE_W-1:0] data;
    } way_line_t;

    way_line_t lines [SETS][WAYS];

    cache_state_t          state_reg, state_next;
    logic [ADDR_SIZE-1:0]  req_addr_reg;
    logic                  req_we_reg;
    logic [DATA_SIZE-1:0]  req_wdata_reg;
    logic [AGE_W-1:0]      victim_reg;
    logic                  rd_sent_reg;
    logic [DATA_SIZE-1:0]  rdata_reg;
    logic                  hit_reg;

    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [OFF_W-1:0]      word_sel;
    logic [WAYS-1:0]       set_valid, way_hit;
    logic [WAYS*AGE_W-1:0] set_ages, new_ages;
    logic [AGE_W-1:0]      hit_way, lru_way, lru_victim;
    logic                  lookup_hit, hit_fire, refill_fire;
    logic [LINE_W-1:0]     merged_line;
    logic [DATA_SIZE-1:0]  read_word;

    assign req_tag  = req_addr_reg[ADDR_SIZE-1 -: TAG_W];
    assign req_idx  = req_addr_reg[OFF_W +: IDX_W];
    assign word_sel = req_addr_reg[OFF_W-1:0] >> WB;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            assign set_valid[gi]              = lines[req_idx][gi].valid;
            assign set_ages[gi*AGE_W +: AGE_W] = lines[req_idx][gi].age;
            assign way_hit[gi] = lines[req_idx][gi].valid && (lines[req_idx][gi].tag == req_tag);
        end
    endgenerate

    assign lookup_hit = |way_hit;

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) hit_way = AGE_W'(w);
        end
    end

    assign hit_fire    = (state_reg == ST_LOOKUP) && lookup_hit;
    assign refill_fire = (state_reg == ST_REFILL) && rd_sent_reg && mem_rsp_valid;
    assign lru_way     = (state_reg == ST_LOOKUP) ? hit_way : victim_reg;

    cache_lru #(.WAYS(WAYS)) u_lru (
        .valid      (set_valid),
        .ages       (set_ages),
        .access_way (lru_way),
        .victim_way (lru_victim),
        .new_ages   (new_ages)
    );

    // Hits merge into the resident line, refills into the incoming one.
    always_comb begin
        merged_line = (state_reg == ST_LOOKUP) ? lines[req_idx][hit_way].data : mem_rsp_rline;
        if (req_we_reg) merged_line[word_sel*DATA_SIZE +: DATA_SIZE] = req_wdata_reg;
    end
    assign read_word = merged_line[word_sel*DATA_SIZE +: DATA_SIZE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    lines[s][w].valid <= 1'b0;
                    lines[s][w].dirty <= 1'b0;
                    lines[s][w].tag   <= '0;
                    lines[s][w].age   <= AGE_W'(w);
                    lines[s][w].data  <= '0;
                end
            end
        end else begin
            if (hit_fire || refill_fire) begin
                for (int w = 0; w < WAYS; w++) begin
                    lines[req_idx][w].age <= new_ages[w*AGE_W +: AGE_W];
                end
            end
            if (hit_fire && req_we_reg) begin
                lines[req_idx][hit_way].data  <= merged_line;
                lines[req_idx][hit_way].dirty <= 1'b1;
            end
            if (refill_fire) begin
                lines[req_idx][victim_reg].valid <= 1'b1;
                lines[req_idx][victim_reg].dirty <= req_we_reg;
                lines[req_idx][victim_reg].tag   <= req_tag;
                lines[req_idx][victim_reg].data  <= merged_line;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            req_addr_reg  <= '0;
            req_we_reg    <= 1'b0;
            req_wdata_reg <= '0;
            victim_reg    <= '0;
            rd_sent_reg   <= 1'b0;
            rdata_reg     <= '0;
            hit_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && req_valid) begin
                req_addr_reg  <= req_addr;
                req_we_reg    <= req_we;
                req_wdata_reg <= req_wdata;
            end
            if (state_reg == ST_LOOKUP) victim_reg <= lru_victim;
            if (hit_fire || refill_fire) begin
                rdata_reg <= read_word;
                hit_reg   <= hit_fire;
            end
            // Refill data only counts once our read request has been taken.
            rd_sent_reg <= (state_next == ST_REFILL) &&
                           (rd_sent_reg || (state_reg == ST_REFILL && mem_req_ready));
        end
    end

    always_comb begin
        state_next    = state_reg;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wline = '0;
        rsp_valid     = 1'b0;
        rsp_hit       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) state_next = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (lookup_hit)
                    state_next = ST_RESPOND;
                else if (lines[req_idx][lru_victim].valid && lines[req_idx][lru_victim].dirty)
                    state_next = ST_WRITEBACK;
                else
                    state_next = ST_REFILL;
            end
            ST_WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {lines[req_idx][victim_reg].tag, req_idx, OFF_W'(0)};
                mem_req_wline = lines[req_idx][victim_reg].data;
                if (mem_req_ready) state_next = ST_REFILL;
            end
            ST_REFILL: begin
                if (!rd_sent_reg) begin
                    mem_req_valid = 1'b1;
                    mem_req_addr  = {req_tag, req_idx, OFF_W'(0)};
                end else if (mem_rsp_valid) begin
                    state_next = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                rsp_valid  = 1'b1;
                rsp_hit    = hit_reg;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign req_ready = rst_n && (state_reg == ST_IDLE);
    assign rsp_rdata = rdata_reg;

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_reg == ST_RESPOND) begin
            if (hit_reg) hit_count  <= sat_inc(hit_count);
            else         miss_count <= sat_inc(miss_count);
        end
    end
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache with a behavioural memory and a response
// scoreboard; define CACHE_STATS_EN to also check the statistics counters.
module tb_set_assoc_cache;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_we = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [31:0]  req_wdata = '0;
    logic         req_ready, rsp_valid, rsp_hit;
    logic [31:0]  rsp_rdata;
    logic         mem_req_valid, mem_req_we;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_wline;
    logic         mem_rsp_valid;
    logic [127:0] mem_rsp_rline;
`ifdef CACHE_STATS_EN
    logic [31:0]  hit_count, miss_count;
`endif

    set_assoc_cache dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_hit       (rsp_hit),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wline (mem_req_wline),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rline (mem_rsp_rline)
`ifdef CACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model state (written only by the memory process).
    logic [127:0] mem_lines [logic [31:0]];
    logic [31:0]  wb_addr_q[$];
    logic [127:0] wb_data_q[$];
    int           rd_count = 0;
    // Memory controls (written only by the main sequence).
    bit           mem_ready_en = 1'b1;
    bit           hold_rsp = 1'b0;
    int           stale_req = 0;

    // Scoreboard of expected responses.
    logic [31:0]  exp_rd_q[$];
    bit           exp_hit_q[$];

    function automatic logic [127:0] gen_line(input logic [31:0] la);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = la ^ (32'h1111_1111 * (i + 1));
        if (la == 32'h40) l[31:0] = 32'hDEAD_BEEF;
        return l;
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] la);
        return mem_lines.exists(la) ? mem_lines[la] : gen_line(la);
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [127:0] l;
        l = mem_line({a[31:4], 4'h0});
        return l[a[3:2]*32 +: 32];
    endfunction

    initial begin
        int cnt;
        int stale_done;
        logic [31:0] rd_a;
        cnt = -1;
        stale_done = 0;
        rd_a = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rline = '0;
        forever begin
            @(negedge clk);
            mem_req_ready = mem_ready_en;
            mem_rsp_valid = 1'b0;
            if (stale_done != stale_req) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rline = {4{32'hBAD0_BAD0}};
                stale_done    = stale_req;
            end else if (cnt == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rline = mem_line(rd_a);
                cnt           = -1;
            end else if (cnt > 0) begin
                cnt--;
            end
            if (!rst_n) begin
                cnt = -1;
            end else if (mem_req_valid && mem_req_ready) begin
                if (mem_req_we) begin
                    mem_lines[mem_req_addr] = mem_req_wline;
                    wb_addr_q.push_back(mem_req_addr);
                    wb_data_q.push_back(mem_req_wline);
                end else begin
                    rd_a = mem_req_addr;
                    rd_count++;
                    if (!hold_rsp) cnt = 2;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input bit exp_hit);
        bit accepted;
        accepted = 1'b0;
        exp_rd_q.push_back(exp_rdata);
        exp_hit_q.push_back(exp_hit);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check($sformatf("accept_%h", addr), accepted, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic wait_rsp(input int exp_lat);
        int   n;
        bit   got;
        logic [31:0] er;
        bit   eh;
        n   = 0;
        got = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                n   = i;
                got = 1'b1;
                break;
            end
        end
        check("rsp_seen", got, 1'b1);
        if (got && exp_rd_q.size() > 0) begin
            er = exp_rd_q.pop_front();
            eh = exp_hit_q.pop_front();
            $display("xact addr=%h rdata=%h hit=%0d lat=%0d", req_addr, rsp_rdata, rsp_hit, n);
            check($sformatf("rdata_%h", req_addr), rsp_rdata, er);
            check($sformatf("hit_%h", req_addr), rsp_hit, eh);
            if (exp_lat > 0) check($sformatf("latency_%h", req_addr), n, exp_lat);
            @(negedge clk);
            check("rsp_one_cycle", rsp_valid, 1'b0);
        end
    endtask

    task automatic xact(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input bit exp_hit);
        send(we, addr, wdata, exp_rdata, exp_hit);
        wait_rsp(exp_hit ? 2 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] exp_wb;
        int prev_rd;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_mem_req_addr", mem_req_addr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1'b1);

        // Refill then hit, write hit, read back
        xact(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0);
        xact(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b1);
        xact(1'b1, 32'h44, 32'h1234_5678, 32'h1234_5678, 1'b1);
        xact(1'b0, 32'h44, 32'h0, 32'h1234_5678, 1'b1);
        xact(1'b0, 32'h48, 32'h0, exp_word(32'h48), 1'b1);

        // Fill set 0, dirty way 0, then touch ways 1..3
        xact(1'b0, 32'h000, 32'h0, exp_word(32'h000), 1'b0);
        xact(1'b0, 32'h200, 32'h0, exp_word(32'h200), 1'b0);
        xact(1'b0, 32'h400, 32'h0, exp_word(32'h400), 1'b0);
        xact(1'b0, 32'h600, 32'h0, exp_word(32'h600), 1'b0);
        xact(1'b1, 32'h004, 32'hA5A5_0001, 32'hA5A5_0001, 1'b1);
        xact(1'b0, 32'h200, 32'h0, exp_word(32'h200), 1'b1);
        xact(1'b0, 32'h400, 32'h0, exp_word(32'h400), 1'b1);
        xact(1'b0, 32'h600, 32'h0, exp_word(32'h600), 1'b1);
        check("no_wb_yet", wb_addr_q.size(), 0);

        // Miss evicts dirty way 0; memory stalls the write-back
        exp_wb = gen_line(32'h000);
        exp_wb[63:32] = 32'hA5A5_0001;
        mem_ready_en = 1'b0;
        send(1'b0, 32'h800, 32'h0, exp_word(32'h800), 1'b0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_mem_valid", mem_req_valid, 1'b1);
            check("stall_mem_we", mem_req_we, 1'b1);
            check("stall_mem_addr", mem_req_addr, 32'h000);
            check("stall_mem_wline", mem_req_wline, exp_wb);
            check("stall_req_ready", req_ready, 1'b0);
            check("stall_rsp_valid", rsp_valid, 1'b0);
        end
        mem_ready_en = 1'b1;
        wait_rsp(0);
        check("wb_count", wb_addr_q.size(), 1);
        if (wb_addr_q.size() > 0) begin
            check("wb_addr", wb_addr_q[0], 32'h000);
            check("wb_data", wb_data_q[0], exp_wb);
        end

        // LRU order after the eviction
        xact(1'b0, 32'h004, 32'h0, 32'hA5A5_0001, 1'b0);
        xact(1'b0, 32'h200, 32'h0, exp_word(32'h200), 1'b0);
        xact(1'b0, 32'h600, 32'h0, exp_word(32'h600), 1'b1);
        xact(1'b0, 32'h800, 32'h0, exp_word(32'h800), 1'b1);
        check("wb_count_clean", wb_addr_q.size(), 1);

        // Reset in the middle of a refill
        hold_rsp = 1'b1;
        prev_rd  = rd_count;
        send(1'b0, 32'h1000, 32'h0, exp_word(32'h1000), 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_count != prev_rd) break;
        end
        check("refill_read_issued", rd_count, prev_rd + 1);
        @(negedge clk);
        rst_n = 1'b0;
        exp_rd_q.delete();
        exp_hit_q.delete();
        @(negedge clk);
        check("mid_rst_req_ready", req_ready, 1'b0);
        check("mid_rst_mem_valid", mem_req_valid, 1'b0);
        check("mid_rst_mem_we", mem_req_we, 1'b0);
        check("mid_rst_mem_addr", mem_req_addr, 32'h0);
        check("mid_rst_mem_wline", mem_req_wline, 128'h0);
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_rsp_hit", rsp_hit, 1'b0);
        check("mid_rst_rdata", rsp_rdata, 32'h0);
        rst_n    = 1'b1;
        hold_rsp = 1'b0;
        stale_req++;
        @(negedge clk);
        check("rel_req_ready", req_ready, 1'b1);
        @(negedge clk);
        check("stale_ignored_ready", req_ready, 1'b1);
        check("stale_ignored_rsp", rsp_valid, 1'b0);

        xact(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0);
        xact(1'b0, 32'h1000, 32'h0, exp_word(32'h1000), 1'b0);
        xact(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b1);
        xact(1'b0, 32'h1000, 32'h0, exp_word(32'h1000), 1'b1);
        xact(1'b0, 32'h44, 32'h0, exp_word(32'h44), 1'b1);

`ifdef CACHE_STATS_EN
        check("hit_count", hit_count, 32'd3);
        check("miss_count", miss_count, 32'd2);
`endif
        check("scoreboard_empty", exp_rd_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/set_assoc_cache.md
SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 SHALL have parameter WAYS, default 4, ways per set (power of 2, >=2).
REQ-002 SHALL have parameter SETS, default 32, sets (power of 2).
REQ-003 SHALL have parameter BLOCK_SIZE, default 16, line size in bytes (power of 2, >=4).
REQ-004 SHALL have parameter ADDR_SIZE, default 32, address bits; DATA_SIZE, default 32, word bits.
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports req_valid in 1, req_ready out 1, req_we in 1, req_addr in ADDR_SIZE, req_wdata in DATA_SIZE: CPU request channel.
REQ-008 SHALL have ports rsp_valid out 1, rsp_rdata out DATA_SIZE, rsp_hit out 1: CPU response; single-cycle pulse, no backpressure.
REQ-009 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_req_we out 1, mem_req_addr out ADDR_SIZE (line-aligned), mem_req_wline out BLOCK_SIZE*8: memory request.
REQ-010 SHALL have ports mem_rsp_valid in 1, mem_rsp_rline in BLOCK_SIZE*8: memory refill data.

Function
REQ-011 SHALL split the address into offset = log2(BLOCK_SIZE), index = log2(SETS) and tag = remainder; address bits [1:0] are ignored.
REQ-012 SHALL implement FSM IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND; req_ready = 1 only in IDLE.
REQ-013 SHALL accept a request when req_valid && req_ready, register it and go to LOOKUP.
REQ-014 On a LOOKUP hit SHALL go to RESPOND; rsp_valid is high exactly 2 cycles after the accept edge, with rsp_hit = 1.
REQ-015 On a write hit SHALL merge req_wdata into the selected word and set dirty; rsp_rdata = written data.
REQ-016 On a miss SHALL select the victim as the lowest-index invalid way, else the way with maximum age.
REQ-017 If the victim is valid and dirty SHALL go to WRITEBACK: mem_req_valid = 1, we = 1, address = {victim tag, index, 0}, held stable until mem_req_ready.
REQ-018 SHALL then (or directly if the victim is clean) go to REFILL: issue a read request held until mem_req_ready, then wait for mem_rsp_valid.
REQ-019 On mem_rsp_valid in REFILL SHALL install the line (valid = 1, new tag, dirty = 0), apply a pending write (dirty = 1), and go to RESPOND with rsp_hit = 0.
REQ-020 SHALL ignore mem_rsp_valid outside REFILL, and during REFILL before the read request has been accepted.
REQ-021 SHALL update LRU on every hit or install: accessed way age = 0; ways in the set with age below the accessed way's old age increment; the others are unchanged.
REQ-022 SHALL keep ages within a set a permutation of 0..WAYS-1 at all times.
REQ-023 RESPOND SHALL last one cycle, then return to IDLE; back-to-back requests to the same line SHALL hit.

Reset
REQ-024 rst_n low SHALL immediately clear all valid and dirty bits and set each way's age = way index.
REQ-025 rst_n low SHALL force state IDLE and drive req_ready = 0 while asserted, and rsp_valid, rsp_hit, mem_req_valid, mem_req_we, rsp_rdata, mem_req_addr and mem_req_wline all = 0.
REQ-026 Reset during WRITEBACK or REFILL SHALL abandon the transfer with no line installed; req_ready = 1 on the first clk edge after release.

Configuration
REQ-027 With CACHE_STATS_EN defined, SHALL add outputs hit_count and miss_count (32 bits each, reset 0, increment once per response by rsp_hit, saturate at all-ones).
REQ-028 Without CACHE_STATS_EN, those ports and counters SHALL be absent.

Structure
REQ-029 Package cache_config SHALL gain the WAYS and SETS defaults, a line struct with valid, dirty, tag, age and data, and the FSM state enum.
REQ-030 Victim selection and age update SHALL live in sub-module cache_lru, parametrised by WAYS.

Verification
REQ-031 Reset, read 0x0000_0040, memory returns a line with word0 = 0xDEADBEEF -> rsp_rdata = 0xDEADBEEF, rsp_hit = 0; the same read again -> hit at latency 2.
REQ-032 Write 0x0000_0044 = 0x12345678 after a refill, then read it -> hit, rsp_rdata = 0x12345678, dirty set.
REQ-033 Fill set 0 with 4 lines, touch ways 1, 2, 3, then miss in set 0 -> way 0 is evicted; dirty victim -> write-back address = old line address with the line data.
REQ-034 Hold mem_req_ready low for 10 cycles in WRITEBACK -> request stable, req_ready = 0, no response.
REQ-035 Assert rst_n low mid-REFILL, then raise mem_rsp_valid after release -> ignored, all lookups miss, req_ready = 1.
REQ-036 With CACHE_STATS_EN: 3 hits and 2 misses -> hit_count = 3, miss_count = 2.
